ex_stage_pipe: RTL and testbench

Parametrised execute stage for the pipelined CPU. It holds the ID/EX pipeline register with stall and flush support, EX-side operand forwarding, and branch-target and zero generation. When `EX_MUL_EN` is defined, it also contains a multi-cycle shift-add multiplier that stalls the front end while it runs. It sits between the ID stage and the EX/MEM register and reuses the existing `Alu` module for single-cycle operations.

---
 rtl/ex_stage_pipe_if.sv | 60 ++++++
 rtl/ex_stage_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pipe_if.sv
// ex_stage_pipe_if: ID -> EX -> MEM bus for the execute stage.
// master: the ID-stage side. It drives the decoded instruction, the forwarding
//         sources and flush, and receives the EX results and the stall request.
// slave : the execute stage itself.
// Parameters: W = datapath width, RA = register-address width.
interface ex_stage_pipe_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned RA = 5
);
  // decoded instruction from ID
  logic          id_valid;
  logic          id_wreg;
  logic          id_m2reg;
  logic          id_wmem;
  logic          id_aluimm;
  logic          id_shift;
  logic          id_branch;
  logic          id_regrt;
  logic [3:0]    id_aluc;
  logic [W-1:0]  id_a_in;
  logic [W-1:0]  id_b_in;
  logic [W-1:0]  id_imm;
  logic [W-1:0]  id_pc4;
  logic [RA-1:0] id_rt;
  logic [RA-1:0] id_rd;
  logic [1:0]    id_fwda;
  logic [1:0]    id_fwdb;
  // forwarding sources and pipeline kill
  logic [W-1:0]  mem_aluR;
  logic [W-1:0]  wb_dest;
  logic          flush;
  // EX results toward MEM, plus the stall request
  logic          ex_busy;
  logic          ex_valid;
  logic          ex_wreg;
  logic          ex_m2reg;
  logic          ex_wmem;
  logic          ex_branch;
  logic [W-1:0]  ex_aluR;
  logic [W-1:0]  ex_inB;
  logic [W-1:0]  ex_pc;
  logic          ex_zero;
  logic [RA-1:0] ex_destR;

  modport master (
    output id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift,
           id_branch, id_regrt, id_aluc, id_a_in, id_b_in, id_imm, id_pc4,
           id_rt, id_rd, id_fwda, id_fwdb, mem_aluR, wb_dest, flush,
    input  ex_busy, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch,
           ex_aluR, ex_inB, ex_pc, ex_zero, ex_destR
  );

  modport slave (
    input  id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift,
           id_branch, id_regrt, id_aluc, id_a_in, id_b_in, id_imm, id_pc4,
           id_rt, id_rd, id_fwda, id_fwdb, mem_aluR, wb_dest, flush,
    output ex_busy, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch,
           ex_aluR, ex_inB, ex_pc, ex_zero, ex_destR
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage of the pipelined CPU.
// It holds the ID/EX register (with flush and stall), does EX-side operand
// forwarding and generates the branch target and the zero flag. Single-cycle
// operations go through Alu.
// The optional multi-cycle shift-add multiplier is enabled with the macro
// EX_MUL_EN. With it, aluc 4'b1111 means MUL and the stage stalls the front end
// through ex_busy for W+1 cycles.
// Ports: clk; rst (synchronous, active-high); bus (ex_stage_pipe_if.slave),
//        which carries the id_* instruction, the mem_aluR/wb_dest forwarding
//        sources, flush, and the ex_* results and ex_busy.
// Alu (in this file): a, b, aluc -> r. The encoding is add x000, sub x100,
//        and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111.
module ex_stage_pipe #(
  parameter int unsigned W  = 32,
  parameter int unsigned RA = 5
) (
  input logic           clk,
  input logic           rst,
  ex_stage_pipe_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic          aluimm;
    logic          shift;
    logic          branch;
    logic          regrt;
    logic [3:0]    aluc;
    logic [1:0]    fwda;
    logic [1:0]    fwdb;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  imm;
    logic [W-1:0]  pc4;
    logic [RA-1:0] rt;
    logic [RA-1:0] rd;
  } idex_t;

  idex_t        e;
  idex_t        id_in;
  logic         busy;
  logic         valid;
  logic [W-1:0] fa;
  logic [W-1:0] fb;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] alu_r;
  logic [W-1:0] result;

  // 00/11 keep the register value; 01 takes MEM, 10 takes WB
  function automatic logic [W-1:0] fwd_mux(input logic [1:0] sel,
                                           input logic [W-1:0] r,
                                           input logic [W-1:0] m,
                                           input logic [W-1:0] w);
    case (sel)
      2'b01:   return m;
      2'b10:   return w;
      default: return r;
    endcase
  endfunction

  // gather the ID-side fields into one record
  always_comb begin
    id_in        = '0;
    id_in.valid  = bus.id_valid;
    id_in.wreg   = bus.id_wreg;
    id_in.m2reg  = bus.id_m2reg;
    id_in.wmem   = bus.id_wmem;
    id_in.aluimm = bus.id_aluimm;
    id_in.shift  = bus.id_shift;
    id_in.branch = bus.id_branch;
    id_in.regrt  = bus.id_regrt;
    id_in.aluc   = bus.id_aluc;
    id_in.fwda   = bus.id_fwda;
    id_in.fwdb   = bus.id_fwdb;
    id_in.a      = bus.id_a_in;
    id_in.b      = bus.id_b_in;
    id_in.imm    = bus.id_imm;
    id_in.pc4    = bus.id_pc4;
    id_in.rt     = bus.id_rt;
    id_in.rd     = bus.id_rd;
  end

  // ID/EX register: reset and flush both load an all-zero bubble; a stall holds
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      e <= '0;
    end else if (!busy) begin
      e <= id_in;
    end
  end

  // operand selection
  assign fa   = fwd_mux(e.fwda, e.a, bus.mem_aluR, bus.wb_dest);
  assign fb   = fwd_mux(e.fwdb, e.b, bus.mem_aluR, bus.wb_dest);
  assign a_in = e.shift  ? W'(e.imm[10:6]) : fa;
  assign b_in = e.aluimm ? e.imm : fb;

  Alu #(.W(W)) u_alu (
    .a    (a_in),
    .b    (b_in),
    .aluc (e.aluc),
    .r    (alu_r)
  );

`ifdef EX_MUL_EN
  localparam logic [3:0]  ALUC_MUL = 4'b1111;
  localparam int unsigned CNT_W    = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_t;

  mul_state_t       state;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic             is_mul;
  logic             mul_req;

  assign is_mul  = (e.aluc == ALUC_MUL);
  assign mul_req = e.valid && is_mul;

  // shift-add multiplier; only the low word is kept, so W-bit registers suffice
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mul_req) begin
            mcand  <= a_in;
            mplier <= b_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(W - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // stall from the MUL's first EX cycle until the product is ready
  assign busy   = (state == S_RUN) || ((state == S_IDLE) && mul_req);
  assign result = is_mul ? acc : alu_r;
`else
  assign busy   = 1'b0;
  assign result = alu_r;
`endif

  assign valid         = e.valid && !busy;
  assign bus.ex_busy   = busy;
  assign bus.ex_valid  = valid;
  assign bus.ex_wreg   = e.wreg   && valid;
  assign bus.ex_m2reg  = e.m2reg  && valid;
  assign bus.ex_wmem   = e.wmem   && valid;
  assign bus.ex_branch = e.branch && valid;
  assign bus.ex_aluR   = result;
  assign bus.ex_inB    = fb;
  // the immediate arrives already scaled by ID
  assign bus.ex_pc     = e.pc4 + e.imm;
  assign bus.ex_zero   = (a_in == b_in);
  assign bus.ex_destR  = e.regrt ? e.rt : e.rd;

endmodule

// Alu: single-cycle integer ALU. Shift amounts come from the low bits of a.
module Alu #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   aluc,
  output logic [W-1:0] r
);
  localparam int unsigned SH_W = $clog2(W);

  logic [SH_W-1:0] sh;
  assign sh = a[SH_W-1:0];

  always_comb begin
    r = '0;
    casez (aluc)
      4'b?000: r = a + b;
      4'b?100: r = a - b;
      4'b?001: r = a & b;
      4'b?101: r = a | b;
      4'b?010: r = a ^ b;
      4'b?110: r = b << 16;
      4'b0011: r = b << sh;
      4'b0111: r = b >> sh;
      4'b1111: r = $signed(b) >>> sh;
      default: r = '0;
    endcase
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed vector table plus hand-written sequences for the
// reset, flush and (with EX_MUL_EN) multi-cycle multiply corners.
module tb_ex_stage_pipe;
  localparam int unsigned W  = 32;
  localparam int unsigned RA = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_pipe_if #(.W(W), .RA(RA)) bus ();
  ex_stage_pipe #(.W(W), .RA(RA)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string         nm;
    logic [3:0]    aluc;
    logic [W-1:0]  a, b, imm, pc4, mem, wb;
    logic [1:0]    fwda, fwdb;
    logic          valid, wreg, wmem, aluimm, shift, branch, regrt;
    logic [RA-1:0] rt, rd;
    logic [W-1:0]  x_alu, x_inb, x_pc;
    logic          x_zero, x_valid, x_wreg, x_branch;
    logic [RA-1:0] x_dest;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t base();
    vec_t v;
    v.nm = "";  v.aluc = 4'd0; v.a = '0; v.b = '0; v.imm = '0; v.pc4 = '0;
    v.mem = 32'd5; v.wb = 32'd9; v.fwda = 2'd0; v.fwdb = 2'd0;
    v.valid = 1'b1; v.wreg = 1'b1; v.wmem = 1'b0; v.aluimm = 1'b0;
    v.shift = 1'b0; v.branch = 1'b0; v.regrt = 1'b0; v.rt = 5'd7; v.rd = 5'd3;
    v.x_alu = '0; v.x_inb = '0; v.x_pc = '0; v.x_zero = 1'b0;
    v.x_valid = 1'b1; v.x_wreg = 1'b1; v.x_branch = 1'b0; v.x_dest = 5'd3;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_valid = v.valid;   bus.id_wreg = v.wreg;     bus.id_m2reg = 1'b0;
    bus.id_wmem = v.wmem;     bus.id_aluimm = v.aluimm; bus.id_shift = v.shift;
    bus.id_branch = v.branch; bus.id_regrt = v.regrt;   bus.id_aluc = v.aluc;
    bus.id_a_in = v.a;        bus.id_b_in = v.b;        bus.id_imm = v.imm;
    bus.id_pc4 = v.pc4;       bus.id_rt = v.rt;         bus.id_rd = v.rd;
    bus.id_fwda = v.fwda;     bus.id_fwdb = v.fwdb;
    bus.mem_aluR = v.mem;     bus.wb_dest = v.wb;
  endtask

`ifdef EX_MUL_EN
  // called just after the edge that loads a MUL; returns in its DONE cycle
  task automatic mul_wait(input string nm, input logic [W-1:0] exp);
    int   n      = 0;
    logic vpulse = 1'b0;
    logic done   = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.ex_busy) begin
        n++;
        vpulse = vpulse | bus.ex_valid | bus.ex_wreg;
        // disturb the forwarding sources once the operands are latched
        if (n == 2) begin
          bus.mem_aluR = 32'd1234;
          bus.wb_dest  = 32'd4321;
        end
        @(posedge clk);
      end else begin
        done = 1'b1;
      end
    end
    chk({nm, "_busy_cycles"}, W'(n), W'(W + 1));
    chk({nm, "_no_early_valid"}, W'(vpulse), '0);
    chk({nm, "_valid"}, W'(bus.ex_valid), W'(1));
    chk({nm, "_wreg"}, W'(bus.ex_wreg), W'(1));
    chk({nm, "_result"}, bus.ex_aluR, exp);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t v2;
    logic vpulse;

    // ---- vector table ----
    v = base(); v.nm = "fwd00"; v.a = 1; v.b = 2; v.x_alu = 3; v.x_inb = 2; vecs.push_back(v);
    v.nm = "fwd01"; v.fwda = 2'd1; v.x_alu = 7;  vecs.push_back(v);
    v.nm = "fwd10"; v.fwda = 2'd2; v.x_alu = 11; vecs.push_back(v);
    v.nm = "fwd11"; v.fwda = 2'd3; v.x_alu = 3;  vecs.push_back(v);
    v = base(); v.nm = "br_eq"; v.pc4 = 32'h100; v.imm = 32'h10; v.a = 32'h2A; v.b = 32'h2A;
    v.branch = 1; v.wreg = 0; v.aluc = 4'b0100; v.x_alu = 0; v.x_inb = 32'h2A;
    v.x_pc = 32'h110; v.x_zero = 1; v.x_wreg = 0; v.x_branch = 1; vecs.push_back(v);
    v.nm = "br_ne"; v.b = 32'h2B; v.x_alu = 32'hFFFF_FFFF; v.x_inb = 32'h2B; v.x_zero = 0;
    vecs.push_back(v);
    v.nm = "br_fwdb01"; v.b = 0; v.fwdb = 2'd1; v.mem = 32'h2A; v.x_alu = 0;
    v.x_inb = 32'h2A; v.x_zero = 1; vecs.push_back(v);
    v = base(); v.nm = "aluimm"; v.aluimm = 1; v.imm = 32'h10; v.a = 5; v.b = 7; v.regrt = 1;
    v.rt = 5'd9; v.x_alu = 32'h15; v.x_inb = 7; v.x_pc = 32'h10; v.x_dest = 5'd9; vecs.push_back(v);
    v = base(); v.nm = "sll_sa"; v.shift = 1; v.imm = 32'h100; v.a = 32'h55; v.b = 3;
    v.aluc = 4'b0011; v.x_alu = 32'h30; v.x_inb = 3; v.x_pc = 32'h100; vecs.push_back(v);
    v = base(); v.nm = "and_fwdb10"; v.aluc = 4'b0001; v.a = 32'hFF; v.fwdb = 2'd2;
    v.x_alu = 9; v.x_inb = 9; vecs.push_back(v);
    v = base(); v.nm = "or"; v.aluc = 4'b0101; v.a = 32'hF0; v.b = 32'h0F; v.x_alu = 32'hFF;
    v.x_inb = 32'h0F; vecs.push_back(v);
    v = base(); v.nm = "xor"; v.aluc = 4'b0010; v.a = 32'hFF; v.b = 32'h0F; v.x_alu = 32'hF0;
    v.x_inb = 32'h0F; vecs.push_back(v);
    v = base(); v.nm = "srl"; v.aluc = 4'b0111; v.a = 4; v.b = 32'h8000_0000;
    v.x_alu = 32'h0800_0000; v.x_inb = 32'h8000_0000; vecs.push_back(v);
    v = base(); v.nm = "lui"; v.aluc = 4'b0110; v.b = 32'h1234; v.x_alu = 32'h1234_0000;
    v.x_inb = 32'h1234; vecs.push_back(v);
    v = base(); v.nm = "bubble_gated"; v.valid = 0; v.branch = 1; v.a = 1; v.b = 2;
    v.x_alu = 3; v.x_inb = 2; v.x_valid = 0; v.x_wreg = 0; v.x_branch = 0; vecs.push_back(v);
    v = base(); v.nm = "pc_wrap"; v.pc4 = 32'hFFFF_FFF0; v.imm = 32'h20; v.x_pc = 32'h10;
    v.x_zero = 1; vecs.push_back(v);
`ifndef EX_MUL_EN
    v = base(); v.nm = "sra_1111"; v.aluc = 4'b1111; v.a = 4; v.b = 32'h8000_0000;
    v.x_alu = 32'hF800_0000; v.x_inb = 32'h8000_0000; vecs.push_back(v);
`endif

    // ---- reset with random ID inputs ----
    rst = 1'b1;
    bus.flush = 1'b0;
    v = base();
    v.aluc = 4'($urandom); v.a = W'($urandom); v.b = W'($urandom); v.imm = W'($urandom);
    v.pc4 = W'($urandom); v.mem = W'($urandom); v.wb = W'($urandom);
    v.fwda = 2'($urandom); v.fwdb = 2'($urandom); v.wmem = 1'b1; v.branch = 1'b1;
    v.rt = 5'($urandom); v.rd = 5'($urandom); v.regrt = 1'($urandom);
    drive(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(bus.ex_busy), '0);
    chk("rst_valid", W'(bus.ex_valid), '0);
    chk("rst_ctrl", W'({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem, bus.ex_branch}), '0);
    chk("rst_aluR", bus.ex_aluR, '0);
    chk("rst_inB", bus.ex_inB, '0);
    chk("rst_pc", bus.ex_pc, '0);
    chk("rst_zero", W'(bus.ex_zero), W'(1));
    chk("rst_destR", W'(bus.ex_destR), '0);
    v = base(); v.valid = 1'b0;
    drive(v);
    rst = 1'b0;

    // ---- table ----
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      chk({vecs[i].nm, "_aluR"}, bus.ex_aluR, vecs[i].x_alu);
      chk({vecs[i].nm, "_inB"}, bus.ex_inB, vecs[i].x_inb);
      chk({vecs[i].nm, "_pc"}, bus.ex_pc, vecs[i].x_pc);
      chk({vecs[i].nm, "_zero"}, W'(bus.ex_zero), W'(vecs[i].x_zero));
      chk({vecs[i].nm, "_destR"}, W'(bus.ex_destR), W'(vecs[i].x_dest));
      chk({vecs[i].nm, "_valid"}, W'(bus.ex_valid), W'(vecs[i].x_valid));
      chk({vecs[i].nm, "_wreg"}, W'(bus.ex_wreg), W'(vecs[i].x_wreg));
      chk({vecs[i].nm, "_branch"}, W'(bus.ex_branch), W'(vecs[i].x_branch));
      chk({vecs[i].nm, "_busy"}, W'(bus.ex_busy), '0);
    end

    // ---- flush of a store entering EX ----
    v = base(); v.wmem = 1'b1; v.wreg = 1'b0; v.a = 1; v.b = 2;
    drive(v);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_valid", W'(bus.ex_valid), '0);
    chk("flush_wmem", W'(bus.ex_wmem), '0);
    bus.flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("store_valid", W'(bus.ex_valid), W'(1));
    chk("store_wmem", W'(bus.ex_wmem), W'(1));

`ifdef EX_MUL_EN
    // ---- back-to-back MULs; the second waits in ID while the first runs ----
    v = base(); v.nm = "mul1"; v.aluc = 4'b1111; v.fwda = 2'd1; v.mem = 7; v.b = 6;
    drive(v);
    @(posedge clk);
    #1;
    v2 = base(); v2.aluc = 4'b1111; v2.a = 32'hFFFF_FFFF; v2.b = 2; v2.mem = 7;
    drive(v2);
    mul_wait("mul_7x6", 32'd42);
    @(posedge clk);
    #1;
    v = base(); v.a = 1; v.b = 2;
    drive(v);
    mul_wait("mul_ffx2", 32'hFFFF_FFFE);
    @(posedge clk);
    @(negedge clk);
    chk("after_mul_add", bus.ex_aluR, 32'd3);
    chk("after_mul_valid", W'(bus.ex_valid), W'(1));

    // ---- flush in RUN cycle 10 aborts the multiply ----
    v = base(); v.aluc = 4'b1111; v.a = 7; v.b = 6;
    drive(v);
    @(posedge clk);
    #1;
    v = base(); v.a = 1; v.b = 2;
    drive(v);
    vpulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vpulse = vpulse | bus.ex_valid;
      @(posedge clk);
    end
    @(negedge clk);
    vpulse = vpulse | bus.ex_valid;
    chk("abort_busy_before", W'(bus.ex_busy), W'(1));
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_after", W'(bus.ex_busy), '0);
    chk("abort_valid", W'(bus.ex_valid), '0);
    chk("abort_no_pulse", W'(vpulse), '0);
    bus.flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_next_add", bus.ex_aluR, 32'd3);
    chk("abort_next_valid", W'(bus.ex_valid), W'(1));
    chk("abort_next_busy", W'(bus.ex_busy), '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
